// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event receiver: event encoding and index sizing.
package btn_event_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  localparam int IDX_MAX_W = 8;

  typedef struct packed {
    logic                 is_press;
    logic [IDX_MAX_W-1:0] index;
  } btn_evt_t;

  function automatic int idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One input line: two-flop synchronizer, stability counter, debounced level and edge pulses.
module btn_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Counter only runs while the synchronized sample disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/btn_event_rx.sv
// Debounced button receiver: per-line edge pulses plus a pending-flag arbiter feeding a
// small first-word-fall-through event FIFO with a sticky overflow flag.
module btn_event_rx
  import btn_event_pkg::*;
#(
  parameter  int WIDTH           = 3,
  parameter  int DEBOUNCE_CYCLES = 100000,
  parameter  int FIFO_DEPTH      = 4,
  localparam int IDX_W           = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W:0]   evt_data,
  output logic             evt_overflow,
  input  logic             clr_overflow
);

  localparam int EVT_W = 1 + IDX_W;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] eff_valid;
  logic [WIDTH-1:0] eff_type;
  logic [WIDTH-1:0] grant;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] ptype_q, ptype_d;
  logic             found;
  logic             ovf_set;
  logic             ovf_q, ovf_d;
  logic [EVT_W-1:0] push_data;

  logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_line
      btn_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_in[g]),
        .level_o(btn_level[g]),
        .rise_o (rise_pulse[g]),
        .fall_o (fall_pulse[g])
      );
    end
  endgenerate

  assign edge_w = rise_pulse | fall_pulse;
  assign full   = (count_q == CNT_FULL);

  // A fresh edge is visible to the arbiter in its pulse cycle, so an idle FIFO reports it
  // one cycle later. An already-pending event keeps priority over a same-cycle new edge.
  always_comb begin
    eff_valid = pend_q | edge_w;
    eff_type  = '0;
    grant     = '0;
    found     = 1'b0;
    push_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      eff_type[i] = pend_q[i] ? ptype_q[i] : (rise_pulse[i] ? EVT_PRESS : EVT_RELEASE);
    end
    if (!full) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (eff_valid[i] && !found) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          push_data = {eff_type[i], IDX_W'(i)};
        end
      end
    end
    pend_d  = (eff_valid & ~grant) | (edge_w & pend_q);
    ptype_d = (edge_w & rise_pulse) | (~edge_w & ptype_q);
    ovf_set = |(edge_w & pend_q & ~grant);
    ovf_d   = ovf_set ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
  end

  // Fullness is judged before any pop, so a full FIFO never accepts a push in a pop cycle.
  always_comb begin
    push     = |grant;
    pop      = evt_valid & evt_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      ptype_q  <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      pend_q   <= pend_d;
      ptype_q  <= ptype_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign evt_valid    = (count_q != '0);
  assign evt_data     = mem_q[rd_ptr_q];
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_btn_event_rx.sv
// Directed bench for btn_event_rx with a sliding-window debounce model and an event queue model.
module tb_btn_event_rx;
  import btn_event_pkg::*;

  localparam int W    = 3;
  localparam int N    = 8;
  localparam int D    = 4;
  localparam int IW   = 2;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  btn_in = '0;
  logic          evt_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [W-1:0]  btn_level, rise_pulse, fall_pulse;
  logic          evt_valid;
  logic [IW:0]   evt_data;
  logic          evt_overflow;

  btn_event_rx #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(N),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .evt_overflow(evt_overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: raw input history plus abstract level/pulse/pending/queue view.
  logic [W-1:0] smp [MAXC];
  bit           rstv [MAXC];
  int           cyc = 0;
  bit           model_on = 1'b0;
  logic [W-1:0] m_lvl, m_rise, m_fall;
  bit           m_ovf;
  bit           m_pend [W];
  bit           m_ptype [W];
  btn_evt_t     m_q [$];

  function automatic logic s_at(input int u, input int i);
    if (u < 2 || u >= MAXC) return 1'b0;
    if (rstv[u-1]) return 1'b0;
    return smp[u-2][i];
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] edges;
    bit           was_full;
    bit           ovset;
    bit           chg;
    bit           wp [W];
    int           pick;
    btn_evt_t     e;
    if (cyc < MAXC) begin
      rstv[cyc] = reset;
      smp[cyc]  = reset ? '0 : btn_in;
    end
    if (reset) begin
      m_lvl  = '0;
      m_rise = '0;
      m_fall = '0;
      m_ovf  = 1'b0;
      m_q.delete();
      for (int i = 0; i < W; i++) begin
        m_pend[i]  = 1'b0;
        m_ptype[i] = 1'b0;
      end
    end else begin
      edges    = m_rise | m_fall;
      was_full = (m_q.size() == D);
      ovset    = 1'b0;
      pick     = -1;
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      for (int i = 0; i < W; i++) wp[i] = m_pend[i];
      if (!was_full) begin
        for (int i = 0; i < W; i++) begin
          if (pick < 0 && (m_pend[i] || edges[i])) pick = i;
        end
      end
      if (pick >= 0) begin
        e.is_press = wp[pick] ? m_ptype[pick] : m_rise[pick];
        e.index    = 8'(pick);
        m_q.push_back(e);
        m_pend[pick] = 1'b0;
      end
      for (int i = 0; i < W; i++) begin
        if (edges[i] && !(pick == i && !wp[i])) begin
          if (wp[i] && pick != i) ovset = 1'b1;
          m_pend[i]  = 1'b1;
          m_ptype[i] = m_rise[i];
        end
      end
      m_ovf = ovset ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
      // A line flips once its last N synchronized samples all disagree with its level.
      for (int i = 0; i < W; i++) begin
        chg = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (cyc - k < 2 || s_at(cyc - k, i) == m_lvl[i]) chg = 1'b0;
        end
        m_rise[i] = chg && !m_lvl[i];
        m_fall[i] = chg && m_lvl[i];
        if (chg) m_lvl[i] = ~m_lvl[i];
      end
    end
    cyc++;
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("level", 32'(btn_level), 32'(m_lvl));
      chk("rise", 32'(rise_pulse), 32'(m_rise));
      chk("fall", 32'(fall_pulse), 32'(m_fall));
      chk("valid", 32'(evt_valid), 32'(m_q.size() != 0));
      chk("overflow", 32'(evt_overflow), 32'(m_ovf));
      if (m_q.size() != 0)
        chk("data", 32'(evt_data), 32'({m_q[0].is_press, m_q[0].index[IW-1:0]}));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  logic [IW:0] exp5 [6];
  logic [IW:0] got5 [$];

  initial begin
    exp5[0] = 3'b100; exp5[1] = 3'b101; exp5[2] = 3'b110;
    exp5[3] = 3'b000; exp5[4] = 3'b101; exp5[5] = 3'b010;

    // 1: reset state and quiet idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("t1_level", 32'(btn_level), 0);
    chk("t1_valid", 32'(evt_valid), 0);
    chk("t1_ovf", 32'(evt_overflow), 0);
    chk("t1_data", 32'(evt_data), 0);
    tick(50);
    chk("t1_valid_idle", 32'(evt_valid), 0);

    // 2: press and release of line 1
    evt_ready = 1'b1;
    btn_in[1] = 1'b1;
    tick(9);
    chk("t2_lvl_early", 32'(btn_level[1]), 0);
    tick(1);
    chk("t2_lvl", 32'(btn_level[1]), 1);
    chk("t2_rise", 32'(rise_pulse), 32'(3'b010));
    tick(1);
    chk("t2_valid", 32'(evt_valid), 1);
    chk("t2_press", 32'(evt_data), 32'(3'b101));
    tick(10);
    btn_in[1] = 1'b0;
    tick(10);
    chk("t2_fall", 32'(fall_pulse), 32'(3'b010));
    chk("t2_lvl_rel", 32'(btn_level[1]), 0);
    tick(1);
    chk("t2_valid_rel", 32'(evt_valid), 1);
    chk("t2_release", 32'(evt_data), 32'(3'b001));
    tick(5);

    // 3: short glitch on line 0
    btn_in[0] = 1'b1;
    tick(5);
    btn_in[0] = 1'b0;
    tick(20);
    chk("t3_level", 32'(btn_level), 0);
    chk("t3_valid", 32'(evt_valid), 0);

    // 4: simultaneous presses on lines 0 and 2
    btn_in = 3'b101;
    tick(10);
    chk("t4_rise", 32'(rise_pulse), 32'(3'b101));
    tick(1);
    chk("t4_first", 32'(evt_data), 32'(3'b100));
    tick(1);
    chk("t4_second", 32'(evt_data), 32'(3'b110));
    tick(1);
    chk("t4_empty", 32'(evt_valid), 0);
    btn_in = 3'b000;
    tick(15);

    // 5: back-pressure, pending events and overflow
    evt_ready = 1'b0;
    btn_in = 3'b111;
    tick(14);
    btn_in = 3'b000;
    tick(14);
    chk("t5_full_valid", 32'(evt_valid), 1);
    chk("t5_no_ovf", 32'(evt_overflow), 0);
    btn_in[1] = 1'b1;
    tick(11);
    chk("t5_ovf", 32'(evt_overflow), 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("t5_ovf_clr", 32'(evt_overflow), 0);
    evt_ready = 1'b1;
    for (int k = 0; k < 40 && got5.size() < 6; k++) begin
      if (evt_valid) got5.push_back(evt_data);
      tick(1);
    end
    chk("t5_count", 32'(got5.size()), 6);
    for (int k = 0; k < got5.size() && k < 6; k++) chk("t5_order", 32'(got5[k]), 32'(exp5[k]));
    btn_in = 3'b000;
    tick(15);

    // 6: reset with queued events while line 1 is held
    evt_ready = 1'b0;
    btn_in = 3'b111;
    tick(14);
    chk("t6_queued", 32'(evt_valid), 1);
    btn_in = 3'b010;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("t6_flushed", 32'(evt_valid), 0);
    chk("t6_lvl_rst", 32'(btn_level), 0);
    evt_ready = 1'b1;
    tick(9);
    chk("t6_lvl_early", 32'(btn_level[1]), 0);
    tick(1);
    chk("t6_rise", 32'(rise_pulse), 32'(3'b010));
    tick(1);
    chk("t6_valid", 32'(evt_valid), 1);
    chk("t6_press", 32'(evt_data), 32'(3'b101));
    tick(15);
    chk("t6_single", 32'(evt_valid), 0);
    chk("t6_lvl_hold", 32'(btn_level), 32'(3'b010));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors + 1, checks);
    $fatal(1, "timeout");
  end

endmodule
